// File: rtl/multicycle_control_fsm.sv
// Multicycle LEGv8 sequencer: FETCH/DECODE/EXEC/MEM/WB with req/ready memories,
// a wait-state watchdog, a retired-instruction counter and an absorbing HALT state.
module multicycle_control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      opcode,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             dmem_read,
    output logic             dmem_write,
    output logic             reg_to_loc,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             pc_write,
    output logic             pc_sel,
    output logic             halted,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned        WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_ILL, C_R, C_LDUR, C_STUR, C_CBZ, C_B
    } cls_t;

    typedef enum logic [1:0] {
        E_NONE    = 2'b00,
        E_ILLEGAL = 2'b01,
        E_TIMEOUT = 2'b10
    } err_t;

    state_t            r_state;
    state_t            w_state_next;
    cls_t              r_cls;
    cls_t              w_cls;
    err_t              r_err;
    err_t              w_err_next;
    logic [WAIT_W-1:0] r_wait;
    logic              w_stalled;
    logic [CNT_W-1:0]  r_retired;

    function automatic cls_t decode(input logic [10:0] op);
        casez (op)
            11'b10001011000,
            11'b11001011000,
            11'b10001010000,
            11'b10101010000: decode = C_R;
            11'b11111000010: decode = C_LDUR;
            11'b11111000000: decode = C_STUR;
            11'b10110100???: decode = C_CBZ;
            11'b000101?????: decode = C_B;
            default:         decode = C_ILL;
        endcase
    endfunction

    // The IR is already stable in DECODE, so decode it live there; later states use the latched class.
    always_comb begin
        w_cls = r_cls;
        if (r_state == S_DECODE) begin
            w_cls = decode(opcode);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_err_next   = r_err;
        imem_req     = 1'b0;
        ir_write     = 1'b0;
        dmem_read    = 1'b0;
        dmem_write   = 1'b0;
        reg_to_loc   = 1'b0;
        alu_src      = 1'b0;
        alu_op       = 2'b00;
        mem_to_reg   = 1'b0;
        reg_write    = 1'b0;
        pc_write     = 1'b0;
        pc_sel       = 1'b0;
        halted       = 1'b0;

        if (r_state == S_DECODE || r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
            case (w_cls)
                C_R:    alu_op = 2'b10;
                C_LDUR: alu_src = 1'b1;
                C_STUR: begin
                    alu_src    = 1'b1;
                    reg_to_loc = 1'b1;
                end
                C_CBZ: begin
                    alu_op     = 2'b01;
                    reg_to_loc = 1'b1;
                end
                default: ;
            endcase
        end

        case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write     = 1'b1;
                    w_state_next = S_DECODE;
                end else if (r_wait == WAIT_LAST) begin
                    w_state_next = S_HALT;
                    w_err_next   = E_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (w_cls == C_ILL) begin
                    w_state_next = S_HALT;
                    w_err_next   = E_ILLEGAL;
                end else begin
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                case (w_cls)
                    C_R:            w_state_next = S_WB;
                    C_LDUR, C_STUR: w_state_next = S_MEM;
                    C_CBZ: begin
                        pc_write     = 1'b1;
                        pc_sel       = zero;
                        w_state_next = S_FETCH;
                    end
                    C_B: begin
                        pc_write     = 1'b1;
                        pc_sel       = 1'b1;
                        w_state_next = S_FETCH;
                    end
                    default: begin
                        w_state_next = S_HALT;
                        w_err_next   = E_ILLEGAL;
                    end
                endcase
            end
            S_MEM: begin
                dmem_read  = (w_cls == C_LDUR);
                dmem_write = (w_cls == C_STUR);
                if (dmem_ready) begin
                    if (w_cls == C_LDUR) begin
                        w_state_next = S_WB;
                    end else begin
                        pc_write     = 1'b1;
                        w_state_next = S_FETCH;
                    end
                end else if (r_wait == WAIT_LAST) begin
                    w_state_next = S_HALT;
                    w_err_next   = E_TIMEOUT;
                end
            end
            S_WB: begin
                reg_write    = 1'b1;
                pc_write     = 1'b1;
                mem_to_reg   = (w_cls == C_LDUR);
                w_state_next = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: w_state_next = S_FETCH;
        endcase

        w_stalled = (w_state_next == r_state) && (r_state == S_FETCH || r_state == S_MEM);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_cls     <= C_ILL;
            r_err     <= E_NONE;
            r_wait    <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_state_next;
            r_err   <= w_err_next;
            if (r_state == S_DECODE) begin
                r_cls <= w_cls;
            end
            // Any state change clears the counter, so it always counts from entry.
            r_wait <= w_stalled ? r_wait + WAIT_W'(1) : '0;
            if (pc_write) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign err_code = r_err;
    assign retired  = r_retired;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: table of instruction vectors with a
// scoreboard queue, plus hand-written reset, halt and watchdog sequences.
module tb_multicycle_control_fsm;

    localparam int unsigned TO = 8;
    localparam int unsigned CW = 4;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;
    localparam logic [10:0] OP_CBZ0 = 11'b10110100000;
    localparam logic [10:0] OP_B    = 11'b00010111111;
    localparam logic [10:0] OP_B0   = 11'b00010100000;

    logic          clk = 1'b0;
    logic          reset;
    logic [10:0]   opcode;
    logic          zero;
    logic          imem_ready;
    logic          dmem_ready;
    logic          imem_req, ir_write, dmem_read, dmem_write, reg_to_loc, alu_src;
    logic [1:0]    alu_op;
    logic          mem_to_reg, reg_write, pc_write, pc_sel, halted;
    logic [1:0]    err_code;
    logic [CW-1:0] retired;

    multicycle_control_fsm #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_write(ir_write), .dmem_read(dmem_read),
        .dmem_write(dmem_write), .reg_to_loc(reg_to_loc), .alu_src(alu_src),
        .alu_op(alu_op), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .pc_write(pc_write), .pc_sel(pc_sel), .halted(halted),
        .err_code(err_code), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] op;
        logic        z;
        int          iw;
        int          dw;
        int          cyc;
        logic        sel;
        logic        rw;
        logic        m2r;
        int          dcyc;
        logic [3:0]  ctl;   // {alu_op, alu_src, reg_to_loc}
    } vec_t;

    vec_t          tbl[12];
    vec_t          sb_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [CW-1:0] exp_ret;

    function automatic vec_t mk(logic [10:0] op, logic z, int iw, int dw, int cyc,
                                logic sel, logic rw, logic m2r, int dcyc, logic [3:0] ctl);
        vec_t v;
        v.op = op; v.z = z; v.iw = iw; v.dw = dw; v.cyc = cyc;
        v.sel = sel; v.rw = rw; v.m2r = m2r; v.dcyc = dcyc; v.ctl = ctl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Leaves the bench at posedge+1 with reset released and the DUT in FETCH.
    task automatic do_reset();
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        reset      = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_ret = '0;
    endtask

    // Runs one instruction from FETCH to its pc_write, then checks it against the queue head.
    task automatic do_instr(input logic [10:0] op, input logic z, input int iw, input int dw);
        int         cyc = 0, ic = 0, dc = 0, dcyc = 0, viol = 0;
        logic       done = 1'b0, rw_seen = 1'b0, m2r_seen = 1'b0, got_sel = 1'b0;
        logic [3:0] got_ctl = '0;
        vec_t       e;
        opcode = op;
        zero   = z;
        while (!done && cyc < 64) begin
            cyc++;
            imem_ready = imem_req && (ic >= iw);
            if (imem_req) ic++;
            dmem_ready = (dmem_read || dmem_write) && (dc >= dw);
            if (dmem_read || dmem_write) dc++;
            @(negedge clk);
            if (dmem_read || dmem_write) dcyc++;
            if ((dmem_read && dmem_write) || (reg_write && dmem_write)) viol++;
            rw_seen  |= reg_write;
            m2r_seen |= mem_to_reg;
            if (pc_write) begin
                done    = 1'b1;
                got_sel = pc_sel;
                got_ctl = {alu_op, alu_src, reg_to_loc};
            end
            @(posedge clk);
            #1;
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'(sb_q.size()), 1);
        end else begin
            e = sb_q.pop_front();
            chk("retire_seen", 32'(done), 1);
            if (done) begin
                exp_ret = exp_ret + 1'b1;
                chk("cycles", cyc, e.cyc);
                chk("pc_sel", 32'(got_sel), 32'(e.sel));
                chk("reg_write", 32'(rw_seen), 32'(e.rw));
                chk("mem_to_reg", 32'(m2r_seen), 32'(e.m2r));
                chk("dmem_cycles", dcyc, e.dcyc);
                chk("held_ctl", 32'(got_ctl), 32'(e.ctl));
                chk("protocol", viol, 0);
                chk("retired", 32'(retired), 32'(exp_ret));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pcw, nh, act, wcnt;
        opcode = '0;
        zero   = 1'b0;

        // Table: op, zero, imem waits, dmem waits, cycles, pc_sel, reg_write, mem_to_reg, dmem cycles, ctl
        tbl[0]  = mk(OP_ADD,  1'b0, 0, 0,  4, 1'b0, 1'b1, 1'b0, 0, 4'b1000);
        tbl[1]  = mk(OP_SUB,  1'b0, 2, 0,  6, 1'b0, 1'b1, 1'b0, 0, 4'b1000);
        tbl[2]  = mk(OP_AND,  1'b1, 0, 0,  4, 1'b0, 1'b1, 1'b0, 0, 4'b1000);
        tbl[3]  = mk(OP_ORR,  1'b0, 7, 0, 11, 1'b0, 1'b1, 1'b0, 0, 4'b1000);
        tbl[4]  = mk(OP_LDUR, 1'b0, 0, 3,  8, 1'b0, 1'b1, 1'b1, 4, 4'b0010);
        tbl[5]  = mk(OP_STUR, 1'b0, 0, 0,  4, 1'b0, 1'b0, 1'b0, 1, 4'b0011);
        tbl[6]  = mk(OP_STUR, 1'b1, 0, 7, 11, 1'b0, 1'b0, 1'b0, 8, 4'b0011);
        tbl[7]  = mk(OP_CBZ,  1'b1, 0, 0,  3, 1'b1, 1'b0, 1'b0, 0, 4'b0101);
        tbl[8]  = mk(OP_CBZ0, 1'b0, 0, 0,  3, 1'b0, 1'b0, 1'b0, 0, 4'b0101);
        tbl[9]  = mk(OP_B,    1'b0, 0, 0,  3, 1'b1, 1'b0, 1'b0, 0, 4'b0000);
        tbl[10] = mk(OP_B0,   1'b0, 3, 0,  6, 1'b1, 1'b0, 1'b0, 0, 4'b0000);
        tbl[11] = mk(OP_LDUR, 1'b0, 0, 0,  5, 1'b0, 1'b1, 1'b1, 1, 4'b0010);

        do_reset();
        chk("rst_imem_req", 32'(imem_req), 1);
        chk("rst_ir_write", 32'(ir_write), 0);
        chk("rst_dmem", 32'({dmem_read, dmem_write}), 0);
        chk("rst_strobes", 32'({reg_write, pc_write}), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_err", 32'(err_code), 0);
        chk("rst_retired", 32'(retired), 0);
        chk("rst_held_ctl", 32'({alu_op, alu_src, reg_to_loc}), 0);

        for (int i = 0; i < 12; i++) begin
            sb_q.push_back(tbl[i]);
            do_instr(tbl[i].op, tbl[i].z, tbl[i].iw, tbl[i].dw);
        end

        // Counter wrap at CNT_W=4: 12 retired so far.
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(tbl[9]);
            do_instr(tbl[9].op, tbl[9].z, tbl[9].iw, tbl[9].dw);
        end
        chk("wrap_pre", 32'(retired), 32'hF);
        sb_q.push_back(tbl[9]);
        do_instr(tbl[9].op, tbl[9].z, tbl[9].iw, tbl[9].dw);
        chk("wrap_zero", 32'(retired), 0);
        sb_q.push_back(tbl[0]);
        do_instr(tbl[0].op, tbl[0].z, tbl[0].iw, tbl[0].dw);

        // Reset in the middle of a stalled LDUR memory phase.
        opcode     = OP_LDUR;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 imem_ready = 1'b0;
        chk("midmem_read", 32'(dmem_read), 1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("midmem_imem_req", 32'(imem_req), 1);
        chk("midmem_dmem_read", 32'(dmem_read), 0);
        chk("midmem_retired", 32'(retired), 0);
        act = 0;
        repeat (3) begin
            @(negedge clk);
            act += int'(reg_write) + int'(pc_write);
        end
        chk("midmem_no_strobe", act, 0);

        // Illegal opcode halts after DECODE and stays halted.
        do_reset();
        opcode     = 11'h000;
        imem_ready = 1'b1;
        @(negedge clk);
        chk("ill_ir_write", 32'(ir_write), 1);
        @(posedge clk);
        #1 chk("ill_decode_not_halted", 32'(halted), 0);
        @(posedge clk);
        #1 chk("ill_halted", 32'(halted), 1);
        chk("ill_err", 32'(err_code), 32'h1);
        pcw = 0; nh = 0; act = 0;
        repeat (20) begin
            @(negedge clk);
            pcw += int'(pc_write);
            nh  += int'(!halted);
            act += int'(imem_req) + int'(dmem_read) + int'(dmem_write) + int'(reg_write);
        end
        chk("ill_no_pc_write", pcw, 0);
        chk("ill_stays_halted", nh, 0);
        chk("ill_no_strobes", act, 0);
        chk("ill_err_hold", 32'(err_code), 32'h1);
        chk("ill_retired", 32'(retired), 0);

        // STUR with dmem_ready stuck low trips the watchdog.
        do_reset();
        opcode     = OP_STUR;
        imem_ready = 1'b1;
        wcnt = 0; pcw = 0;
        for (int c = 0; c < 40 && !halted; c++) begin
            @(negedge clk);
            wcnt += int'(dmem_write);
            pcw  += int'(pc_write);
            @(posedge clk);
            #1;
        end
        chk("to_dmem_write_cycles", wcnt, TO);
        chk("to_halted", 32'(halted), 1);
        chk("to_err", 32'(err_code), 32'h2);
        chk("to_no_pc_write", pcw, 0);
        chk("to_write_dropped", 32'(dmem_write), 0);

        // Instruction fetch that never completes also times out.
        do_reset();
        wcnt = 0;
        for (int c = 0; c < 40 && !halted; c++) begin
            @(negedge clk);
            wcnt += int'(imem_req);
            @(posedge clk);
            #1;
        end
        chk("fto_req_cycles", wcnt, TO);
        chk("fto_halted", 32'(halted), 1);
        chk("fto_err", 32'(err_code), 32'h2);

        chk("sb_empty", 32'(sb_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
